// File: rtl/leaky_relu_derivative_array.sv
// leaky_relu_derivative_array: per-column leaky-ReLU backward stage fed by a private cache of forward pre-activations
module leaky_relu_derivative_array #(
    parameter int N_COLS  = 2,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int H_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_W-1:0]                    lr_leak_factor_in,
    input  logic                                 lr_h_clear_in,
    input  logic [N_COLS-1:0]                    lr_h_wr_en_in,
    input  logic [N_COLS*DATA_W-1:0]             lr_h_wr_data_in,
    input  logic [N_COLS-1:0]                    lr_d_valid_in,
    input  logic [N_COLS*DATA_W-1:0]             lr_d_data_in,
    output logic [N_COLS*DATA_W-1:0]             lr_d_data_out,
    output logic [N_COLS-1:0]                    lr_d_valid_out,
    output logic [N_COLS*($clog2(H_DEPTH)+1)-1:0] lr_h_count_out,
    output logic [N_COLS-1:0]                    lr_h_overflow_out,
    output logic [N_COLS-1:0]                    lr_h_underflow_out
);
    localparam int PW  = $clog2(H_DEPTH);
    localparam int CW  = PW + 1;
    localparam int PDW = 2 * DATA_W;
    localparam logic [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PDW-1:0] SMAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PDW-1:0] SMIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [DATA_W-1:0] leak;
    assign leak = lr_leak_factor_in;
    for (genvar i = 0; i < N_COLS; i++) begin : g_col
        logic [DATA_W-1:0] mem [H_DEPTH];
        logic [PW-1:0] rd_ptr, wr_ptr;
        logic [CW-1:0] count;
        logic [DATA_W-1:0] d_q, res;
        logic v_q, ovf, udf, empty, full, pop, push;
        logic signed [DATA_W-1:0] d, h;
        logic signed [PDW-1:0] p, r;
        always_comb begin
            d     = lr_d_data_in[i*DATA_W +: DATA_W];
            empty = count == '0;
            full  = count == CW'(H_DEPTH);
            // an empty cache reads as H=0 so the gradient takes the leak path
            h     = empty ? '0 : mem[rd_ptr];
            pop   = lr_d_valid_in[i] && !empty && !lr_h_clear_in;
            push  = lr_h_wr_en_in[i] && (!full || pop) && !lr_h_clear_in;
            p     = PDW'(d) * PDW'(leak);
            r     = p >>> FRAC_W;
            res   = (!h[DATA_W-1] && h != '0) ? d : r > SMAX ? DMAX : r < SMIN ? DMIN : r[DATA_W-1:0];
        end
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= lr_h_wr_data_in[i*DATA_W +: DATA_W];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                d_q    <= '0;
                v_q    <= 1'b0;
                ovf    <= 1'b0;
                udf    <= 1'b0;
            end else begin
                if (lr_h_clear_in) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop) rd_ptr <= rd_ptr + 1'b1;
                    count <= count + CW'(push) - CW'(pop);
                end
                v_q <= lr_d_valid_in[i];
                if (lr_d_valid_in[i]) d_q <= res;
                ovf <= ovf | (lr_h_wr_en_in[i] & full & ~pop & ~lr_h_clear_in);
                udf <= udf | (lr_d_valid_in[i] & empty);
            end
        end
        assign lr_d_data_out[i*DATA_W +: DATA_W] = d_q;
        assign lr_d_valid_out[i]                 = v_q;
        assign lr_h_count_out[i*CW +: CW]        = count;
        assign lr_h_overflow_out[i]              = ovf;
        assign lr_h_underflow_out[i]             = udf;
    end
endmodule

// File: tb/tb_leaky_relu_derivative_array.sv
// tb_leaky_relu_derivative_array: randomized bench against a queue-based model of the leaky-ReLU backward stage
module tb_leaky_relu_derivative_array;
    localparam int N  = 2;
    localparam int W  = 16;
    localparam int F  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] leak = '0;
    logic clear = 1'b0;
    logic [N-1:0] wr_en = '0, d_valid = '0;
    logic [N*W-1:0] wr_data = '0, d_data = '0;
    logic [N*W-1:0] d_out;
    logic [N-1:0] v_out, ovf_out, udf_out;
    logic [N*CW-1:0] cnt_out;

    int hq [N][$];
    logic [W-1:0] m_data [N];
    logic m_valid [N], m_ovf [N], m_udf [N];
    int checks = 0, errors = 0;

    leaky_relu_derivative_array #(.N_COLS(N), .DATA_W(W), .FRAC_W(F), .H_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .lr_leak_factor_in(leak), .lr_h_clear_in(clear),
        .lr_h_wr_en_in(wr_en), .lr_h_wr_data_in(wr_data), .lr_d_valid_in(d_valid),
        .lr_d_data_in(d_data), .lr_d_data_out(d_out), .lr_d_valid_out(v_out),
        .lr_h_count_out(cnt_out), .lr_h_overflow_out(ovf_out), .lr_h_underflow_out(udf_out)
    );

    always #5 clk = ~clk;

    function automatic int sx(logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // derivative from the arithmetic definition: pass-through for H>0, else floor(d*leak/2^F) clamped
    function automatic int ref_out(int d, int h, int lk);
        longint r;
        if (h > 0) return d;
        r = (longint'(d) * longint'(lk)) >>> F;
        if (r > (longint'(1) <<< (W-1)) - 1) r = (longint'(1) <<< (W-1)) - 1;
        if (r < -(longint'(1) <<< (W-1))) r = -(longint'(1) <<< (W-1));
        return int'(r);
    endfunction

    task automatic idle();
        rst = 1'b0; clear = 1'b0; wr_en = '0; d_valid = '0;
    endtask

    task automatic set_h(int c, logic [W-1:0] v);
        wr_en[c] = 1'b1; wr_data[c*W +: W] = v;
    endtask

    task automatic set_d(int c, logic [W-1:0] v);
        d_valid[c] = 1'b1; d_data[c*W +: W] = v;
    endtask

    task automatic tick();
        int n, h;
        bit popped;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                hq[c].delete();
                m_data[c] = '0; m_valid[c] = 1'b0; m_ovf[c] = 1'b0; m_udf[c] = 1'b0;
            end else begin
                n = hq[c].size();
                h = n > 0 ? hq[c][0] : 0;
                popped = d_valid[c] && n > 0;
                if (d_valid[c]) begin
                    m_data[c] = W'(ref_out(sx(d_data[c*W +: W]), h, sx(leak)));
                    if (n == 0) m_udf[c] = 1'b1;
                end
                m_valid[c] = d_valid[c];
                if (clear) hq[c].delete();
                else begin
                    if (popped) void'(hq[c].pop_front());
                    if (wr_en[c]) begin
                        if (n < D || popped) hq[c].push_back(sx(wr_data[c*W +: W]));
                        else m_ovf[c] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            leak = W'($urandom); clear = 1'($urandom);
            wr_en = N'($urandom); d_valid = N'($urandom);
            wr_data = {$urandom, $urandom}; d_data = {$urandom, $urandom};
            tick();
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if ({v_out[c], ovf_out[c], udf_out[c], cnt_out[c*CW +: CW], d_out[c*W +: W]} !== '0) begin
                errors++;
                $display("FAIL reset col%0d got v=%b ovf=%b udf=%b cnt=%0d data=%h exp all zero",
                         c, v_out[c], ovf_out[c], udf_out[c], cnt_out[c*CW +: CW], d_out[c*W +: W]);
            end
        end
        idle();
    endtask

    task automatic test_basic();
        idle(); leak = 16'h0080; set_h(0, 16'h0100); set_h(1, 16'hFF00); tick();
        idle(); set_d(0, 16'h0200); set_d(1, 16'h0200); tick();
        checks++;
        if (d_out !== {16'h0100, 16'h0200} || v_out !== 2'b11) begin
            errors++;
            $display("FAIL basic_pos_neg got data=%h v=%b exp data=01000200 v=11", d_out, v_out);
        end
        idle(); set_h(0, 16'h0000); tick();
        idle(); set_d(0, 16'h0200); tick();
        checks++;
        if (d_out !== {16'h0100, 16'h0100} || v_out !== 2'b01) begin
            errors++;
            $display("FAIL basic_zero_h got data=%h v=%b exp data=01000100 v=01", d_out, v_out);
        end
        idle(); tick();
        checks++;
        if (v_out !== 2'b00 || cnt_out !== '0 || d_out !== {16'h0100, 16'h0100}) begin
            errors++;
            $display("FAIL basic_hold got data=%h v=%b cnt=%h exp data=01000100 v=00 cnt=0", d_out, v_out, cnt_out);
        end
    endtask

    task automatic test_saturation();
        idle(); leak = 16'h7FFF; set_h(0, 16'hFF00); set_h(1, 16'h8000); tick();
        idle(); set_d(0, 16'h7FFF); set_d(1, 16'h8000); tick();
        checks++;
        if (d_out !== {16'h8000, 16'h7FFF}) begin
            errors++;
            $display("FAIL sat got %h exp 80007fff", d_out);
        end
        idle(); leak = 16'h0080; set_h(0, 16'hFFFF); tick();
        idle(); set_d(0, 16'hFFFF); tick();
        checks++;
        if (d_out[W-1:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL floor_half_lsb got %h exp ffff", d_out[W-1:0]);
        end
    endtask

    task automatic test_fifo_wrap();
        int pushes [N], pops [N], cyc;
        logic [W-1:0] v;
        pushes = '{12, 12}; pops = '{12, 12}; cyc = 0;
        while ((pops[0] > 0 || pops[1] > 0) && cyc < 200) begin
            idle(); leak = W'($urandom);
            for (int c = 0; c < N; c++) begin
                if (pushes[c] > 0 && hq[c].size() < D && $urandom_range(0, 1) == 1) begin
                    v = (pushes[c] % 2 == 0) ? W'($urandom_range(1, 32767)) : W'(-int'($urandom_range(0, 32768)));
                    set_h(c, v); pushes[c]--;
                end
                if (hq[c].size() > 0 && ($urandom_range(0, 1) == 1 || pushes[c] == 0)) begin
                    set_d(c, W'($urandom)); pops[c]--;
                end
            end
            tick(); cyc++;
            for (int c = 0; c < N; c++) begin
                checks++;
                if (v_out[c] !== m_valid[c] || d_out[c*W +: W] !== m_data[c] ||
                    int'(cnt_out[c*CW +: CW]) != hq[c].size() || cnt_out[c*CW +: CW] > CW'(D) ||
                    ovf_out[c] !== 1'b0 || udf_out[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap col%0d cyc%0d got v=%b d=%h cnt=%0d ovf=%b udf=%b exp v=%b d=%h cnt=%0d ovf=0 udf=0",
                             c, cyc, v_out[c], d_out[c*W +: W], cnt_out[c*CW +: CW], ovf_out[c], udf_out[c],
                             m_valid[c], m_data[c], hq[c].size());
                end
            end
        end
        checks++;
        if (pops[0] != 0 || pops[1] != 0) begin
            errors++;
            $display("FAIL wrap_budget got pops left %0d/%0d exp 0/0", pops[0], pops[1]);
        end
    endtask

    task automatic test_boundaries();
        idle(); leak = 16'h0080;
        for (int k = 0; k < D; k++) begin
            idle(); set_h(0, W'($urandom)); set_h(1, W'($urandom)); tick();
        end
        idle(); set_h(0, W'($urandom)); tick();
        checks++;
        if (cnt_out !== {CW'(D), CW'(D)} || ovf_out !== 2'b01) begin
            errors++;
            $display("FAIL overflow got cnt=%h ovf=%b exp cnt=88 ovf=01", cnt_out, ovf_out);
        end
        idle();
        for (int c = 0; c < N; c++) begin set_h(c, W'($urandom)); set_d(c, W'($urandom)); end
        tick();
        checks++;
        if (cnt_out !== {CW'(D), CW'(D)} || ovf_out !== 2'b01 || d_out !== {m_data[1], m_data[0]}) begin
            errors++;
            $display("FAIL full_push_pop got cnt=%h ovf=%b d=%h exp cnt=88 ovf=01 d=%h%h",
                     cnt_out, ovf_out, d_out, m_data[1], m_data[0]);
        end
        for (int k = 0; k < D; k++) begin
            idle(); leak = W'($urandom); set_d(0, W'($urandom)); set_d(1, W'($urandom)); tick();
            for (int c = 0; c < N; c++) begin
                checks++;
                if (d_out[c*W +: W] !== m_data[c] || int'(cnt_out[c*CW +: CW]) != hq[c].size()) begin
                    errors++;
                    $display("FAIL drain col%0d got d=%h cnt=%0d exp d=%h cnt=%0d",
                             c, d_out[c*W +: W], cnt_out[c*CW +: CW], m_data[c], hq[c].size());
                end
            end
        end
        idle(); leak = 16'h0080; set_d(0, 16'h0200); tick();
        checks++;
        if (udf_out !== 2'b01 || v_out !== 2'b01 || d_out[W-1:0] !== 16'h0100 || cnt_out !== '0) begin
            errors++;
            $display("FAIL underflow got udf=%b v=%b d=%h cnt=%h exp udf=01 v=01 d=0100 cnt=0",
                     udf_out, v_out, d_out[W-1:0], cnt_out);
        end
    endtask

    task automatic test_clear_and_reset();
        for (int k = 0; k < 5; k++) begin
            idle(); set_h(0, W'($urandom)); if (k < 3) set_h(1, W'($urandom)); tick();
        end
        checks++;
        if (cnt_out !== {CW'(3), CW'(5)}) begin
            errors++;
            $display("FAIL clear_setup got cnt=%h exp 35", cnt_out);
        end
        idle(); leak = W'($urandom); clear = 1'b1;
        for (int c = 0; c < N; c++) begin set_h(c, W'($urandom)); set_d(c, W'($urandom)); end
        tick();
        checks++;
        if (cnt_out !== '0 || d_out !== {m_data[1], m_data[0]} || ovf_out !== 2'b01 || udf_out !== 2'b01) begin
            errors++;
            $display("FAIL clear got cnt=%h d=%h ovf=%b udf=%b exp cnt=0 d=%h%h ovf=01 udf=01",
                     cnt_out, d_out, ovf_out, udf_out, m_data[1], m_data[0]);
        end
        for (int k = 0; k < 4; k++) begin
            idle(); leak = W'($urandom);
            for (int c = 0; c < N; c++) begin set_h(c, W'($urandom)); set_d(c, W'($urandom)); end
            tick();
            for (int c = 0; c < N; c++) begin
                checks++;
                if (v_out[c] !== m_valid[c] || d_out[c*W +: W] !== m_data[c] || udf_out[c] !== m_udf[c] ||
                    int'(cnt_out[c*CW +: CW]) != hq[c].size()) begin
                    errors++;
                    $display("FAIL burst col%0d got v=%b d=%h udf=%b cnt=%0d exp v=%b d=%h udf=%b cnt=%0d",
                             c, v_out[c], d_out[c*W +: W], udf_out[c], cnt_out[c*CW +: CW],
                             m_valid[c], m_data[c], m_udf[c], hq[c].size());
                end
            end
        end
        rst = 1'b1; tick();
        checks++;
        if (v_out !== '0 || ovf_out !== '0 || udf_out !== '0 || cnt_out !== '0 || d_out !== '0) begin
            errors++;
            $display("FAIL mid_reset got v=%b ovf=%b udf=%b cnt=%h d=%h exp all zero", v_out, ovf_out, udf_out, cnt_out, d_out);
        end
        idle(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_fifo_wrap();
        test_boundaries();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
